// File: rtl/reg_dump_streamer.sv
// Debug read-out engine: walks a register id range on the core debug port and streams (id, value) words.
// Build macro REG_DUMP_SKIP_ZERO_EN: when defined, register 0 is never selected or emitted.
module reg_dump_streamer #(
    parameter int NUM_REGS = 32,
    parameter int ID_W     = 5,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ID_W-1:0]   first_id,
    input  logic [ID_W-1:0]   last_id,
    output logic [ID_W-1:0]   reg_out_id,
    input  logic [DATA_W-1:0] reg_out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ID_W-1:0]   out_id,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
`ifdef REG_DUMP_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif
    localparam logic [ID_W-1:0] TOP_ID = ID_W'(NUM_REGS - 1);
    localparam logic [1:0]      LAT    = 2'(READ_LAT);

    typedef enum logic [2:0] {IDLE, SEL, WAIT, SEND, DONE} state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] cur, end_id, sel_id, nxt_id, eff_end;
    logic [1:0]      cnt;
    logic            reject_q;
    logic            accept, reject, sel_load, capture, advance, xfer;

    // Id arithmetic: wrap at NUM_REGS-1, optionally hop over register 0.
    always_comb begin
        sel_id  = (SKIP_ZERO && cur == '0) ? ID_W'(1) : cur;
        nxt_id  = (cur == TOP_ID) ? '0 : cur + 1'b1;
        if (SKIP_ZERO && nxt_id == '0)
            nxt_id = ID_W'(1);
        eff_end = (SKIP_ZERO && end_id == '0) ? TOP_ID : end_id;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        sel_load = 1'b0;
        capture  = 1'b0;
        advance  = 1'b0;
        xfer     = out_valid && out_ready;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (int'(first_id) >= NUM_REGS || int'(last_id) >= NUM_REGS) begin
                        reject = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        state_nx = SEL;
                    end
                end
            end
            SEL: begin
                if (SKIP_ZERO && cur == '0 && end_id == '0) begin
                    state_nx = DONE;
                end else begin
                    sel_load = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (out_last) begin
                        state_nx = DONE;
                    end else begin
                        advance  = 1'b1;
                        state_nx = WAIT;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur        <= '0;
            end_id     <= '0;
            cnt        <= '0;
            reject_q   <= 1'b0;
            reg_out_id <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= '0;
            out_last   <= 1'b0;
        end else begin
            state    <= state_nx;
            reject_q <= reject;
            if (accept) begin
                cur    <= first_id;
                end_id <= last_id;
            end
            if (sel_load) begin
                cur        <= sel_id;
                reg_out_id <= sel_id;
                cnt        <= LAT;
            end
            if (state == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if (capture) begin
                out_valid <= 1'b1;
                out_data  <= reg_out_data;
                out_id    <= cur;
                out_last  <= (cur == eff_end);
            end
            if (xfer)
                out_valid <= 1'b0;
            // Next id is selected on the handshake edge itself so the stream
            // sustains one word every READ_LAT+2 cycles with out_ready high.
            if (advance) begin
                cur        <= nxt_id;
                reg_out_id <= nxt_id;
                cnt        <= LAT;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE) || reject_q;

endmodule

// File: doc/reg_dump_streamer.md
Name: reg_dump_streamer

Overview:
- Debug read-out engine for the Mips core.
- Drives the core's reg_out_id select and samples reg_out_data.
- Walks a requested register range and streams each (id, value) pair out over a valid/ready interface.
- Lets a host or bench dump architectural state without poking hierarchical paths.

Parameters:
- NUM_REGS, 32: number of architectural registers; ids are 0..NUM_REGS-1.
- ID_W, 5: width of register ids; must satisfy 2**ID_W >= NUM_REGS.
- DATA_W, 32: register data width.
- READ_LAT, 1: cycles from reg_out_id change to reg_out_data valid; legal 0..3.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- first_id  in  ID_W  first register of the range; sampled with start.
- last_id  in  ID_W  last register of the range; sampled with start.
- reg_out_id  out  ID_W  register select to the core debug port.
- reg_out_data  in  DATA_W  register value from the core debug port.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accepts the word when out_valid && out_ready.
- out_data  out  DATA_W  captured register value.
- out_id  out  ID_W  id of the register in out_data.
- out_last  out  1  marks the final word of the dump.
- busy  out  1  high from the cycle after start acceptance until DONE exits.
- done  out  1  one-cycle pulse after the last word handshakes.

Behaviour:
- Reset values: state IDLE; reg_out_id=0; out_valid=0; out_data=0; out_id=0; out_last=0; busy=0; done=0. Internal cur/last/wait counters cleared.
- Reset asserted mid-dump aborts immediately, with no done pulse.
- States: IDLE, SEL, WAIT, SEND, DONE.
- IDLE:
  - On start=1: latch first_id into cur and last_id into end, then go to SEL.
  - start while not IDLE is ignored and not queued.
  - first_id or last_id >= NUM_REGS: the request is rejected. Stay IDLE and pulse done with no words.
- SEL:
  - Drive reg_out_id=cur and load wait counter=READ_LAT.
  - READ_LAT=0: go directly to capture (next bullet).
  - Otherwise go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When it reaches 0, capture reg_out_data into out_data and cur into out_id, set out_valid=1, and go to SEND.
  - out_last=1 iff cur==end.
- SEND:
  - out_data, out_id and out_last are held stable while out_valid=1 && out_ready=0.
  - Handshake not last: clear out_valid and advance cur, then go to SEL.
  - cur advances as cur==NUM_REGS-1 ? 0 : cur+1.
  - Handshake with last: clear out_valid and go to DONE.
- DONE: done=1 for one cycle, busy=0 on exit, return to IDLE.
- Range rules:
  - first<=last: dumps first..last in order.
  - first>last: wraps, dumping first..NUM_REGS-1 then 0..last.
  - first==last: exactly one word.
- reg_out_id holds the value of the last register selected while idle; the core debug port is read-only, so this has no side effects.
- Throughput with out_ready held high is one word per READ_LAT+2 cycles. First out_valid appears READ_LAT+2 cycles after the start edge.
- out_ready may be asserted before out_valid. Only out_valid && out_ready counts as a transfer.

Optional Feature:
- Macro: REG_DUMP_SKIP_ZERO_EN.
- When defined: register id 0 (MIPS $zero) is never selected or emitted.
  - If cur==0 in SEL, advance without reading.
  - out_last is computed against the last non-zero id in the range.
  - A range consisting solely of id 0 produces no words and goes straight to DONE with the done pulse.
- When undefined: id 0 is dumped like any other register.

Test Plan:
- Basic range: core regs r1=5, r2=10, r3=15; start with first=1, last=3, out_ready=1. Expect words (1,5), (2,10), (3,15), each 3 cycles apart at READ_LAT=1; out_last only on id 3; done pulses 1 cycle after.
- Backpressure: same dump with out_ready low for 4 cycles on word 2. Expect out_data=10 and out_id=2 stable throughout; no duplicated or skipped words.
- Wrap: first=30, last=1 with r30=0x1E, r31=0x1F, r1=0x1. Expect ids 30, 31, 0, 1 in order and out_last on id 1 (without REG_DUMP_SKIP_ZERO_EN). With the macro, expect ids 30, 31, 1.
- Single/ignore: first=last=7. Expect exactly one word with out_last=1. A second start pulsed while busy is ignored: only one done pulse.
- Reset abort: assert reset during SEND of word 2. Expect all outputs 0 asynchronously, no done pulse, and a fresh start afterwards dumps correctly.
- Latency sweep: READ_LAT=0 and READ_LAT=3. Expect first out_valid 2 and 5 cycles after start respectively, with correct values.
